// File: rtl/instr_sequencer_if.sv
// Bus bundle between the sequencer, the instruction memory, the regfile and the ALU.
// The master side is the sequencer.
interface instr_sequencer_if;
    logic [4:0]  pc;
    logic [16:0] instr;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [1:0]  alu_op;
    logic        alu_valid;
    logic        alu_done;

    modport master (
        output pc, rf_raddr1, rf_raddr2, rf_we, rf_waddr, alu_op, alu_valid,
        input  instr, alu_done
    );

    modport slave (
        input  pc, rf_raddr1, rf_raddr2, rf_we, rf_waddr, alu_op, alu_valid,
        output instr, alu_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM for the E8 datapath.
// Owns the program counter and the instruction register.
module instr_sequencer #(
    parameter logic [4:0]  START_PC = 5'd0,
    parameter logic [4:0]  LAST_PC  = 5'd31,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o,
    instr_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [4:0]       pc_q, pc_d;
    logic [16:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ir_live;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= StIdle;
            pc_q      <= START_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pc_d      = START_PC;
                    retired_d = '0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                ir_d    = bus.instr;
                state_d = StDecode;
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (bus.alu_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                if (retired_q != '1) begin
                    retired_d = retired_q + CntOne;
                end
                if (pc_q == LAST_PC) begin
                    state_d = StDone;
                end else begin
                    pc_d    = pc_q + 5'd1;
                    state_d = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort freezes all architectural state and wins over every transition, WB included.
        if (abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            pc_d      = pc_q;
            ir_d      = ir_q;
            retired_d = retired_q;
        end
    end

    always_comb begin
        ir_live       = (state_q == StDecode) || (state_q == StExec) || (state_q == StWb);
        busy_o        = (state_q != StIdle);
        done_o        = (state_q == StDone) && !abort_i;
        retired_o     = retired_q;
        bus.pc        = pc_q;
        bus.rf_raddr1 = ir_live ? ir_q[9:5]   : 5'd0;
        bus.rf_raddr2 = ir_live ? ir_q[4:0]   : 5'd0;
        bus.rf_waddr  = ir_live ? ir_q[14:10] : 5'd0;
        bus.alu_op    = ir_live ? ir_q[16:15] : 2'd0;
        bus.rf_we     = (state_q == StWb);
        bus.alu_valid = (state_q == StExec);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: three instances with different PC ranges and counter widths.
// Instruction at address p is {p[1:0], p^7, p+1, p+2}.
module tb_instr_sequencer;

    logic clk;
    logic rstN;
    logic start_a, abort_a, busy_a, done_a;
    logic start_b, abort_b, busy_b, done_b;
    logic start_c, abort_c, busy_c, done_c;
    logic [7:0] retired_a, retired_b;
    logic [1:0] retired_c;
    int n_checks;
    int n_errors;

    instr_sequencer_if bus_a ();
    instr_sequencer_if bus_b ();
    instr_sequencer_if bus_c ();

    function automatic logic [16:0] imem(input logic [4:0] p);
        logic [4:0] wa, r1, r2;
        wa = p ^ 5'd7;
        r1 = p + 5'd1;
        r2 = p + 5'd2;
        return {p[1:0], wa, r1, r2};
    endfunction

    assign bus_a.instr = imem(bus_a.pc);
    assign bus_b.instr = imem(bus_b.pc);
    assign bus_c.instr = imem(bus_c.pc);

    instr_sequencer #(.START_PC(5'd0), .LAST_PC(5'd2), .CNT_W(8)) u_a (
        .clk(clk), .rstN(rstN), .start_i(start_a), .abort_i(abort_a),
        .busy_o(busy_a), .done_o(done_a), .retired_o(retired_a), .bus(bus_a)
    );

    instr_sequencer #(.START_PC(5'd30), .LAST_PC(5'd1), .CNT_W(8)) u_b (
        .clk(clk), .rstN(rstN), .start_i(start_b), .abort_i(abort_b),
        .busy_o(busy_b), .done_o(done_b), .retired_o(retired_b), .bus(bus_b)
    );

    instr_sequencer #(.START_PC(5'd0), .LAST_PC(5'd5), .CNT_W(2)) u_c (
        .clk(clk), .rstN(rstN), .start_i(start_c), .abort_i(abort_c),
        .busy_o(busy_c), .done_o(done_c), .retired_o(retired_c), .bus(bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of cycle 1 (FETCH).
    task automatic start_run(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstN = 1'b0;
        {start_a, abort_a, start_b, abort_b, start_c, abort_c} = '0;
        bus_a.alu_done = 1'b0;
        bus_b.alu_done = 1'b1;
        bus_c.alu_done = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst pc_a", 32'(bus_a.pc), 0);
        chk("rst pc_b", 32'(bus_b.pc), 30);
        chk("rst busy", 32'(busy_a), 0);
        chk("rst done", 32'(done_a), 0);
        chk("rst retired", 32'(retired_a), 0);
        chk("rst we", 32'(bus_a.rf_we), 0);
        chk("rst valid", 32'(bus_a.alu_valid), 0);
        chk("rst raddr1", 32'(bus_a.rf_raddr1), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Three instructions, ALU answers immediately.
        bus_a.alu_done = 1'b1;
        start_run(0);
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("t1 we c%0d", c), 32'(bus_a.rf_we), 32'(c == 4 || c == 8 || c == 12));
            chk($sformatf("t1 done c%0d", c), 32'(done_a), 32'(c == 13));
            chk($sformatf("t1 valid c%0d", c), 32'(bus_a.alu_valid), 32'(c == 3 || c == 7 || c == 11));
            case (c)
                1:  chk("t1 waddr idle-ir", 32'(bus_a.rf_waddr), 0);
                2:  chk("t1 raddr", 32'({bus_a.rf_raddr1, bus_a.rf_raddr2}), 32'({5'd1, 5'd2}));
                4:  chk("t1 waddr0", 32'(bus_a.rf_waddr), 7);
                7:  chk("t1 aluop1", 32'(bus_a.alu_op), 1);
                8:  chk("t1 waddr1", 32'(bus_a.rf_waddr), 6);
                12: chk("t1 waddr2", 32'(bus_a.rf_waddr), 5);
                14: begin
                    chk("t1 busy end", 32'(busy_a), 0);
                    chk("t1 retired", 32'(retired_a), 3);
                    chk("t1 pc end", 32'(bus_a.pc), 2);
                end
                default: ;
            endcase
            @(negedge clk);
        end

        // ALU late by 3 cycles on the first instruction; start pulsed mid-run is ignored.
        bus_a.alu_done = 1'b0;
        start_run(0);
        for (int c = 1; c <= 17; c++) begin
            bus_a.alu_done = (c >= 6);
            start_a = (c == 9);
            chk($sformatf("t2 valid c%0d", c), 32'(bus_a.alu_valid),
                32'((c >= 3 && c <= 6) || c == 10 || c == 14));
            chk($sformatf("t2 we c%0d", c), 32'(bus_a.rf_we), 32'(c == 7 || c == 11 || c == 15));
            chk($sformatf("t2 done c%0d", c), 32'(done_a), 32'(c == 16));
            if (c == 17) begin
                chk("t2 busy end", 32'(busy_a), 0);
                chk("t2 retired", 32'(retired_a), 3);
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        bus_a.alu_done = 1'b1;

        // Abort in EXEC of the second instruction.
        start_run(0);
        for (int c = 1; c <= 14; c++) begin
            abort_a = (c == 7);
            chk($sformatf("t4 we c%0d", c), 32'(bus_a.rf_we), 32'(c == 4));
            chk($sformatf("t4 done c%0d", c), 32'(done_a), 0);
            if (c == 8) chk("t4 busy", 32'(busy_a), 0);
            if (c == 14) begin
                chk("t4 retired", 32'(retired_a), 1);
                chk("t4 pc", 32'(bus_a.pc), 1);
            end
            @(negedge clk);
        end
        abort_a = 1'b0;

        // Abort in WB: rf_we still pulses, but nothing retires and pc holds.
        start_run(0);
        for (int c = 1; c <= 6; c++) begin
            abort_a = (c == 4);
            chk($sformatf("t4b we c%0d", c), 32'(bus_a.rf_we), 32'(c == 4));
            if (c == 5) chk("t4b busy", 32'(busy_a), 0);
            if (c == 6) begin
                chk("t4b retired", 32'(retired_a), 0);
                chk("t4b pc", 32'(bus_a.pc), 0);
            end
            @(negedge clk);
        end
        abort_a = 1'b0;

        // Reset during DECODE of the second instruction of a wrapping run.
        start_run(1);
        for (int c = 1; c < 6; c++) @(negedge clk);
        chk("t5 pc pre", 32'(bus_b.pc), 31);
        chk("t5 retired pre", 32'(retired_b), 1);
        chk("t5 raddr2 pre", 32'(bus_b.rf_raddr2), 1);
        rstN = 1'b0;
        #1;
        chk("t5 pc rst", 32'(bus_b.pc), 30);
        chk("t5 busy rst", 32'(busy_b), 0);
        chk("t5 raddr2 rst", 32'(bus_b.rf_raddr2), 0);
        chk("t5 retired rst", 32'(retired_b), 0);
        chk("t5 we rst", 32'(bus_b.rf_we), 0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Wrapping run 30,31,0,1.
        start_run(1);
        for (int c = 1; c <= 18; c++) begin
            chk($sformatf("t3 we c%0d", c), 32'(bus_b.rf_we), 32'(c % 4 == 0 && c <= 16));
            chk($sformatf("t3 done c%0d", c), 32'(done_b), 32'(c == 17));
            case (c)
                1:  chk("t3 pc0", 32'(bus_b.pc), 30);
                5:  chk("t3 pc1", 32'(bus_b.pc), 31);
                9:  chk("t3 pc2", 32'(bus_b.pc), 0);
                13: chk("t3 pc3", 32'(bus_b.pc), 1);
                4:  chk("t3 waddr0", 32'(bus_b.rf_waddr), 25);
                8:  chk("t3 waddr1", 32'(bus_b.rf_waddr), 24);
                12: chk("t3 waddr2", 32'(bus_b.rf_waddr), 7);
                16: chk("t3 waddr3", 32'(bus_b.rf_waddr), 6);
                18: begin
                    chk("t3 busy end", 32'(busy_b), 0);
                    chk("t3 retired", 32'(retired_b), 4);
                    chk("t3 pc end", 32'(bus_b.pc), 1);
                end
                default: ;
            endcase
            @(negedge clk);
        end

        // Six instructions through a 2-bit counter.
        start_run(2);
        for (int c = 1; c <= 26; c++) begin
            chk($sformatf("t6 done c%0d", c), 32'(done_c), 32'(c == 25));
            case (c)
                5:  chk("t6 retired1", 32'(retired_c), 1);
                13: chk("t6 retired3", 32'(retired_c), 3);
                24: chk("t6 last we", 32'(bus_c.rf_we), 1);
                26: begin
                    chk("t6 retired sat", 32'(retired_c), 3);
                    chk("t6 busy end", 32'(busy_c), 0);
                end
                default: ;
            endcase
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
